// File: rtl/spi_mstr.sv
// SPI master: 8/16-bit frames, MSB first, selectable slave-sampling edge.
// Define SPI_MSTR_MISO_EN to add MISO capture into rd_data.
module spi_mstr #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] data_out,
    input  logic        pos_edge,
    input  logic        width8,
`ifdef SPI_MSTR_MISO_EN
    input  logic        MISO,
    output logic [15:0] rd_data,
`endif
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bits;
    logic [15:0]   sr;
    logic          pe;
    logic          w8;
    logic          half_end;
    logic          last_bit;
`ifdef SPI_MSTR_MISO_EN
    logic [15:0]   rx;
`endif

    assign half_end = (cnt == CW'(HALF - 1));
    assign last_bit = (bits == (w8 ? 4'd7 : 4'd15));
    assign MOSI     = sr[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            sr    <= '0;
            pe    <= 1'b0;
            w8    <= 1'b0;
            SS_n  <= 1'b1;
            SCLK  <= 1'b1;
            done  <= 1'b0;
`ifdef SPI_MSTR_MISO_EN
            rx      <= '0;
            rd_data <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (wrt) begin
                        sr    <= width8 ? {data_out[7:0], 8'h00} : data_out;
                        pe    <= pos_edge;
                        w8    <= width8;
                        bits  <= '0;
                        cnt   <= '0;
                        SS_n  <= 1'b0;
                        done  <= 1'b0;
                        state <= FRONT;
`ifdef SPI_MSTR_MISO_EN
                        rx    <= '0;
`endif
                    end
                end
                FRONT: begin
                    if (half_end) begin
                        cnt   <= '0;
                        SCLK  <= 1'b0;
                        state <= SHIFT;
`ifdef SPI_MSTR_MISO_EN
                        if (!pe) rx <= {rx[14:0], MISO};
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    cnt <= half_end ? '0 : cnt + CW'(1);
                    // Low half ends in a rise, high half ends in a fall
                    if (half_end && !SCLK) begin
                        SCLK <= 1'b1;
                        if (!pe && !last_bit) sr <= {sr[14:0], 1'b0};
`ifdef SPI_MSTR_MISO_EN
                        if (pe) rx <= {rx[14:0], MISO};
`endif
                    end else if (half_end) begin
                        if (last_bit) begin
                            state <= BACK;
                        end else begin
                            SCLK <= 1'b0;
                            bits <= bits + 4'd1;
                            if (pe) sr <= {sr[14:0], 1'b0};
`ifdef SPI_MSTR_MISO_EN
                            if (!pe) rx <= {rx[14:0], MISO};
`endif
                        end
                    end
                end
                BACK: begin
                    if (half_end) begin
                        cnt   <= '0;
                        SS_n  <= 1'b1;
                        done  <= 1'b1;
                        sr    <= '0;
                        state <= IDLE;
`ifdef SPI_MSTR_MISO_EN
                        rd_data <= w8 ? {8'h00, rx[7:0]} : rx;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mstr.sv
// Randomized scoreboard bench for spi_mstr; a bus monitor decodes
// each SS_n frame and compares it with the expected frame queue.
module tb_spi_mstr;

    localparam int DIV = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] data_out = '0;
    logic        pos_edge = 1'b0;
    logic        width8 = 1'b0;
    logic        ss_n, sclk, mosi, done;
`ifdef SPI_MSTR_MISO_EN
    logic [15:0] rd_data;
`endif

    always #5 clk = ~clk;

    spi_mstr #(.SCLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrt      (wrt),
        .data_out (data_out),
        .pos_edge (pos_edge),
        .width8   (width8),
`ifdef SPI_MSTR_MISO_EN
        .MISO     (mosi),
        .rd_data  (rd_data),
`endif
        .SS_n     (ss_n),
        .SCLK     (sclk),
        .MOSI     (mosi),
        .done     (done)
    );

    typedef struct {
        logic [15:0] word;
        int          n;
        logic        pe;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    // Monitor: decodes what a slave would see on each frame
    exp_t        cur;
    logic        active = 1'b0;
    logic [15:0] rbits;
    int          nb, len, bad;
    logic        p_sclk = 1'b1, p_mosi = 1'b0, p_ss = 1'b1;

    always @(negedge clk) begin
        logic rise, fall, samp, nsamp;
        logic [15:0] got;
        if (!rst_n) begin
            active = 1'b0;
        end else begin
            if (p_ss && !ss_n) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    active = 1'b0;
                end else begin
                    cur = q.pop_front();
                    active = 1'b1;
                    rbits = '0;
                    nb = 0;
                    len = 0;
                    bad = 0;
                    chk("done_clear_at_ss_fall", {31'd0, done}, 0);
                end
            end
            if (active && !ss_n) begin
                len++;
                rise = !p_sclk && sclk;
                fall = p_sclk && !sclk;
                samp = cur.pe ? rise : fall;
                nsamp = cur.pe ? fall : rise;
                if (samp) begin
                    rbits = {rbits[14:0], p_mosi};
                    nb++;
                end
                if (mosi !== p_mosi && !nsamp && !p_ss) bad++;
            end
            if (active && !p_ss && ss_n) begin
                got = (cur.n == 8) ? {8'h00, rbits[7:0]} : rbits;
                chk("ss_low_clocks", len, (cur.n + 1) * DIV);
                chk("sample_edges", nb, cur.n);
                chk("frame_bits", {16'd0, got}, {16'd0, cur.word});
                chk("mosi_stability", bad, 0);
                chk("done_at_ss_rise", {31'd0, done}, 1);
                chk("mosi_cleared", {31'd0, mosi}, 0);
`ifdef SPI_MSTR_MISO_EN
                chk("rd_data", {16'd0, rd_data}, {16'd0, cur.word});
`endif
                active = 1'b0;
            end
        end
        p_sclk = sclk;
        p_mosi = mosi;
        p_ss = ss_n;
    end

    task automatic send(input logic [15:0] d, input logic pe,
                        input logic w8);
        exp_t e;
        int t = 0;
        while (ss_n !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("idle_timeout", 1, 0);
        wrt = 1'b1;
        data_out = d;
        pos_edge = pe;
        width8 = w8;
        e.word = w8 ? {8'h00, d[7:0]} : d;
        e.n = w8 ? 8 : 16;
        e.pe = pe;
        q.push_back(e);
        @(negedge clk);
        wrt = 1'b0;
        data_out = 16'($urandom);
        pos_edge = 1'($urandom);
        width8 = 1'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("done_timeout", 1, 0);
    endtask

    initial begin
        int toggles;
        logic last;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", {31'd0, ss_n}, 1);
        chk("rst_sclk", {31'd0, sclk}, 1);
        chk("rst_mosi", {31'd0, mosi}, 0);
        chk("rst_done", {31'd0, done}, 0);
`ifdef SPI_MSTR_MISO_EN
        chk("rst_rd_data", {16'd0, rd_data}, 0);
`endif
        rst_n = 1'b1;
        toggles = 0;
        last = sclk;
        repeat (100) begin
            @(negedge clk);
            if (sclk !== last || ss_n !== 1'b1) toggles++;
            last = sclk;
        end
        chk("idle_no_activity", toggles, 0);
        chk("idle_done", {31'd0, done}, 0);

        send(16'hBEEF, 1'b1, 1'b0);
        send(16'hBEEF, 1'b0, 1'b0);
        send(16'hBEEF, 1'b0, 1'b1);
        send(16'hA55A, 1'b1, 1'b0);

        // Pulses of wrt and input churn during a frame are ignored
        send(16'hBEEF, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wrt = 1'b1;
            data_out = 16'($urandom);
            pos_edge = 1'($urandom);
            width8 = 1'($urandom);
            @(negedge clk);
            wrt = 1'b0;
            repeat (40) @(negedge clk);
        end

        // Back-to-back: wrt issued in the cycle done is first seen
        wait_done();
        send(16'h1234, 1'b0, 1'b0);
        wait_done();
        send(16'h00C3, 1'b1, 1'b1);

        // Reset mid-SHIFT aborts the frame
        send(16'($urandom), 1'($urandom), 1'b0);
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ss_n", {31'd0, ss_n}, 1);
        chk("abort_sclk", {31'd0, sclk}, 1);
        chk("abort_mosi", {31'd0, mosi}, 0);
        chk("abort_done", {31'd0, done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'hBEEF, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            if (i % 4 == 3) wait_done();
            send(16'($urandom), 1'($urandom), 1'($urandom));
        end

        begin
            int t = 0;
            while ((q.size() != 0 || active || ss_n !== 1'b1) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) chk("drain_timeout", 1, 0);
        end
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_mstr.md
# spi_mstr

Synthesizable SPI master that serializes a 16-bit or 8-bit word onto SS_n/SCLK/MOSI, MSB first, with selectable data/sampling edge. It is the stimulus source for exercising the logic analyzer's SPI protocol trigger. It runs on the 100 MHz system clock alongside the UART protocol-trigger source.

## Interface
- SCLK_DIV, 32: system clocks per SCLK period; power of two, ≥4.
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wrt  input  1  start request, sampled in IDLE only.
- data_out  input  16  word to send; latched on accepted wrt.
- pos_edge  input  1  1: slave samples on SCLK rise; 0: slave samples on SCLK fall. Latched with wrt.
- width8  input  1  1: send data_out[7:0] (8 bits); 0: send all 16 bits. Latched with wrt.
- SS_n  output  1  active-low slave select.
- SCLK  output  1  serial clock, idles high.
- MOSI  output  1  serial data = shift register bit 15.
- done  output  1  transfer complete, held until next accepted wrt.

## Operation
- Shift register 16 bits. Load: width8 ? {data_out[7:0],8'h00} : data_out. N = width8 ? 8 : 16.
- States: IDLE, FRONT, SHIFT, BACK.
- IDLE: SS_n=1, SCLK=1. wrt=1 → latch, SS_n←0, done←0, → FRONT. Otherwise stay.
- FRONT: SCLK high for SCLK_DIV/2 clocks; MOSI presents MSB. → SHIFT.
- SHIFT: N periods. Each period: SCLK low SCLK_DIV/2 clocks (starts with fall), then high SCLK_DIV/2 clocks.
  - pos_edge=1: shift left on falls of periods 2..N; slave samples on every rise.
  - pos_edge=0: shift left on rises of periods 1..N-1; slave samples on every fall.
  - After period N, SCLK is high. → BACK.
- BACK: SCLK high for SCLK_DIV/2 more clocks. Then SS_n←1, done←1, shift register cleared so MOSI=0. → IDLE.
- wrt outside IDLE is ignored. data_out/pos_edge/width8 changes after latch have no effect.
- Shift fill bit is 0.
- Reset mid-transfer aborts immediately to IDLE with reset values.

## Timing
- Reset values: SS_n=1, SCLK=1, MOSI=0, done=0; state IDLE, counters 0.
- SS_n falls on the first clock edge after wrt is sampled high.
- SCLK first fall occurs SCLK_DIV/2 clocks after SS_n falls.
- SS_n low for exactly (N+1)·SCLK_DIV clocks:
  - 16 bits, SCLK_DIV=32: 544 clocks.
  - 8 bits: 288 clocks.
- done rises on the same edge as SS_n. The next wrt is accepted that same cycle or later.
- MOSI is stable ≥ SCLK_DIV/2 clocks before each sampling edge and changes only on the non-sampling edge, or at SS_n fall for the MSB.
- All outputs are registered; no glitches.

## Configuration
- SPI_MSTR_MISO_EN defined:
  - Adds input MISO and output rd_data[15:0] (reset 0).
  - MISO is shifted in on each slave-sampling edge (same edge the slave samples MOSI).
  - At done: rd_data = 16 received bits, or {8'h00, received byte} for width8.
- Not defined: no MISO/rd_data ports; behaviour otherwise identical.

## Test plan
- Reset, then idle 100 clocks → SS_n=1, SCLK=1, MOSI=0, done=0, no SCLK edges.
- wrt with 16'hBEEF, pos_edge=1, width8=0 → bits sampled on SCLK rises = 1011111011101111; 16 rises; SS_n low 544 clocks; done=1 at SS_n rise.
- Same word with pos_edge=0 → bits sampled on falls = 16'hBEEF; MOSI never changes within 1 clock of a fall.
- width8=1, data_out=16'hBEEF → 8 periods sending 8'hEF; SS_n low 288 clocks.
- wrt pulsed repeatedly mid-transfer, then data_out changed → single unaffected BEEF frame. Back-to-back wrt on done → second frame, done cleared on the first edge after wrt.
- Assert rst_n low mid-SHIFT → outputs immediately at reset values. A new wrt after release sends a complete frame.
- With SPI_MSTR_MISO_EN: MISO looped from MOSI, send 16'hA55A → rd_data=16'hA55A at done.
